seq_divider: RTL and testbench



---
 rtl/seq_div_pkg.sv | 19 +
 rtl/seq_div_step.sv | 38 +++
 rtl/seq_divider.sv | 174 +++++++++++++++++
 tb/tb_seq_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width, and the
// iteration-counter width helper used by seq_divider.
package seq_div_pkg;

  localparam int SEQ_DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter must reach 2*width without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// Purpose: one combinational restoring-division iteration.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
// Ports:
//   rem_in  [WIDTH-1:0] partial remainder before this step
//   bit_in              next dividend bit shifted into the remainder
//   divisor [WIDTH-1:0] divisor
//   rem_out [WIDTH-1:0] partial remainder after this step
//   q_bit               quotient bit produced by this step
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] selected;
  logic           trial_msb_unused;

  assign partial = {rem_in, bit_in};
  assign trial   = partial - {1'b0, divisor};

  // No borrow means the divisor fits into the shifted remainder.
  assign q_bit    = (partial >= {1'b0, divisor});
  assign selected = q_bit ? trial : partial;

  // Whenever rem_in < divisor the kept value is below the divisor and fits
  // WIDTH bits. With a zero divisor the top bit is discarded on purpose, which
  // turns the remainder into a plain shift of the dividend's low bits.
  assign rem_out          = selected[WIDTH-1:0];
  assign trial_msb_unused = selected[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Purpose: sequential unsigned restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Latency: 2*WIDTH CALC cycles after the accept edge; one op per 2*WIDTH+2 cycles.
// Backpressure: result held stable in DONE until out_ready; in_ready low while busy.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     operand handshake (dividend, divisor)
//   out_valid/out_ready   result handshake (quotient, remainder)
//   div_by_zero           only when SEQ_DIV_ZERO_DETECT_EN is defined
// Optional feature macro: SEQ_DIV_ZERO_DETECT_EN, which short-circuits a zero
// divisor straight to DONE and flags it on div_by_zero.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = SEQ_DIV_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder
`ifdef SEQ_DIV_ZERO_DETECT_EN
  ,
  output logic                 div_by_zero
`endif
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [QW-1:0]    quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    count_q, count_d;

  logic             accept;
  logic             last_iter;
  logic             step_bit;
  logic [WIDTH-1:0] step_rem;

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic div_by_zero_q, div_by_zero_d;
  logic zero_div;
  assign zero_div = (divisor == '0);
`endif

  assign accept    = in_valid & in_ready;
  assign last_iter = (count_q == CW'(QW - 1));

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder and the new quotient bit enters at the LSB.
  seq_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (remainder_q),
    .bit_in  (quotient_q[QW-1]),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      quotient_q    <= '0;
      remainder_q   <= '0;
      divisor_q     <= '0;
      count_q       <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      div_by_zero_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      divisor_q     <= divisor_d;
      count_q       <= count_d;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      div_by_zero_q <= div_by_zero_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
          state_d = zero_div ? ST_DONE : ST_CALC;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    divisor_d     = divisor_q;
    count_d       = count_q;
`ifdef SEQ_DIV_ZERO_DETECT_EN
    div_by_zero_d = div_by_zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          quotient_d  = dividend;
          divisor_d   = divisor;
          remainder_d = '0;
          count_d     = '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
          div_by_zero_d = 1'b0;
          // Same numeric result the full iteration would produce.
          if (zero_div) begin
            quotient_d    = '1;
            remainder_d   = dividend[WIDTH-1:0];
            div_by_zero_d = 1'b1;
          end
`endif
        end
      end
      ST_CALC: begin
        quotient_d  = {quotient_q[QW-2:0], step_bit};
        remainder_d = step_rem;
        count_d     = count_q + CW'(1);
      end
      ST_DONE: begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
        if (out_ready) begin
          div_by_zero_d = 1'b0;
        end
`endif
      end
      default: begin
        quotient_d = quotient_q;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign div_by_zero = div_by_zero_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed vector table,
// hand-written backpressure / reset / back-to-back sequences, and a random
// sweep against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          dbz_w;

  int tests  = 0;
  int failed = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_ZERO_DETECT_EN
    ,
    .div_by_zero (dbz_w)
`endif
  );

`ifndef SEQ_DIV_ZERO_DETECT_EN
  assign dbz_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Edges after the accept edge before out_valid is seen. A zero divisor with
  // detection enabled lands in DONE on the accept edge itself, so out_valid is
  // up in the very next cycle.
  function automatic int exp_lat(input logic [7:0] dvs);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    if (dvs == 8'd0) return 0;
`endif
    return 2 * W;
  endfunction

  // Reference model straight from the arithmetic definition.
  function automatic logic [15:0] model_q(input logic [15:0] dvd, input logic [7:0] dvs);
    if (dvs == 8'd0) return 16'hFFFF;
    return dvd / {8'd0, dvs};
  endfunction

  function automatic logic [7:0] model_r(input logic [15:0] dvd, input logic [7:0] dvs);
    logic [15:0] r;
    if (dvs == 8'd0) return dvd[7:0];
    r = dvd % {8'd0, dvs};
    return r[7:0];
  endfunction

  // Presents operands, waits for acceptance and the result. If out_ready is
  // high the handoff edge is also consumed, leaving the DUT in IDLE.
  task automatic do_op(input logic [15:0] dvd, input logic [7:0] dvs,
                       output logic [15:0] q, output logic [7:0] r,
                       output int lat, output logic dbz);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    for (int n = 0; n < 100 && !in_ready; n++) tick();
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    q   = quotient;
    r   = remainder;
    dbz = dbz_w;
    if (out_ready) tick();
  endtask

  vec_t        vecs[$];
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;
  int          lat;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_quotient",  {16'd0, quotient},  32'd0);
    check("reset_remainder", {24'd0, remainder}, 32'd0);
    check("reset_dbz",       {31'd0, dbz_w},     32'd0);

    vecs.push_back('{16'd1000,  8'd7,   16'd142,   8'd6});
    vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0});
    vecs.push_back('{16'd5,     8'd200, 16'd0,     8'd5});
    vecs.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34});
    vecs.push_back('{16'd200,   8'd9,   16'd22,    8'd2});
    vecs.push_back('{16'd0,     8'd5,   16'd0,     8'd0});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0});
    vecs.push_back('{16'd65535, 8'd0,   16'hFFFF,  8'hFF});
    vecs.push_back('{16'd65535, 8'd128, 16'd511,   8'd127});

    foreach (vecs[i]) begin
      do_op(vecs[i].dvd, vecs[i].dvs, q, r, lat, dbz);
      check($sformatf("vec%0d_quotient", i),  {16'd0, q}, {16'd0, vecs[i].exp_q});
      check($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].exp_r});
      check($sformatf("vec%0d_latency", i),   lat, exp_lat(vecs[i].dvs));
`ifdef SEQ_DIV_ZERO_DETECT_EN
      check($sformatf("vec%0d_dbz", i), {31'd0, dbz}, {31'd0, (vecs[i].dvs == 8'd0)});
`endif
    end

    // Backpressure: result must stay put for 10 cycles with out_ready low.
    out_ready = 1'b0;
    do_op(16'd1000, 8'd7, q, r, lat, dbz);
    check("bp_first_quotient", {16'd0, q}, 32'd142);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i),
            {12'd0, out_valid, in_ready, quotient, remainder[1:0]},
            {12'd0, 1'b1, 1'b0, 16'd142, 2'd2});
      check($sformatf("bp_rem%0d", i), {24'd0, remainder}, 32'd6);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready",  {31'd0, in_ready},  32'd1);

    // Reset in the 5th CALC cycle throws the operation away.
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_in_ready",  {31'd0, in_ready},  32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_quotient",  {16'd0, quotient},  32'd0);
    check("midreset_remainder", {24'd0, remainder}, 32'd0);
    do_op(16'd200, 8'd9, q, r, lat, dbz);
    check("postreset_quotient",  {16'd0, q}, 32'd22);
    check("postreset_remainder", {24'd0, r}, 32'd2);

    // Back-to-back with in_valid held high throughout.
    in_valid = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    for (int n = 0; n < 100 && in_ready; n++) tick();
    dividend = 16'd200;
    divisor  = 8'd9;
    for (int n = 0; n < 100 && !out_valid; n++) tick();
    check("b2b_first_quotient",  {16'd0, quotient},  32'd142);
    check("b2b_first_remainder", {24'd0, remainder}, 32'd6);
    tick();
    check("b2b_handoff_in_ready",  {31'd0, in_ready},  32'd1);
    check("b2b_handoff_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !out_valid; n++) tick();
    check("b2b_second_quotient",  {16'd0, quotient},  32'd22);
    check("b2b_second_remainder", {24'd0, remainder}, 32'd2);
    tick();

    // Random sweep against the reference model and the division identity.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] dvd;
      logic [7:0]  dvs;
      dvd = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       dvs = 8'd0;
        1, 2:    dvs = 8'($urandom_range(1, 15));
        default: dvs = 8'($urandom);
      endcase
      do_op(dvd, dvs, q, r, lat, dbz);
      check($sformatf("rand%0d_q(%0d/%0d)", i, dvd, dvs), {16'd0, q}, {16'd0, model_q(dvd, dvs)});
      check($sformatf("rand%0d_r(%0d/%0d)", i, dvd, dvs), {24'd0, r}, {24'd0, model_r(dvd, dvs)});
      check($sformatf("rand%0d_lat", i), lat, exp_lat(dvs));
      if (dvs != 8'd0) begin
        check($sformatf("rand%0d_identity", i),
              ({16'd0, q} * {24'd0, dvs}) + {24'd0, r}, {16'd0, dvd});
        check($sformatf("rand%0d_rem_lt_div", i), {31'd0, (r < dvs)}, 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
